// File: rtl/channel_scanner_pkg.sv
// channel_scanner_pkg: shared FSM state type and default sizes for the channel scanner and mux
package channel_scanner_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DATA_LENGTH = 68;
  typedef enum logic [1:0] {IDLE, SELECT, OUTPUT} state_t;
endpackage

// File: rtl/channel_scanner_if.sv
// channel_scanner_if: pending/mux-select/ack side plus the valid/ready word stream
interface channel_scanner_if import channel_scanner_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DATA_LENGTH = DEF_DATA_LENGTH
);
  localparam int SW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  logic [WIDTH-1:0] i_pending;
  logic [SW-1:0] o_sel;
  logic [DATA_LENGTH-1:0] i_data;
  logic [WIDTH-1:0] o_ack;
  logic [DATA_LENGTH-1:0] o_data;
  logic [SW-1:0] o_channel;
  logic o_valid;
  logic i_ready;
  modport master (
    input i_pending, i_data, i_ready,
    output o_sel, o_ack, o_data, o_channel, o_valid
  );
  modport slave (
    output i_pending, i_data, i_ready,
    input o_sel, o_ack, o_data, o_channel, o_valid
  );
endinterface

// File: rtl/channel_scanner_rr_arbiter.sv
// rr_arbiter: grants the first request at or after ptr, wrapping at WIDTH-1
module rr_arbiter import channel_scanner_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  localparam int SW = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [SW-1:0]    ptr,
  output logic             grant_valid,
  output logic [SW-1:0]    grant_idx
);
  logic [WIDTH-1:0] rot;
  int pick;
  // modulo wrap keeps the index below WIDTH even when WIDTH is not a power of two
  always_comb begin
    rot = '0;
    pick = 0;
    for (int i = 0; i < WIDTH; i++) rot[i] = req[(i + int'(ptr)) % WIDTH];
    for (int i = WIDTH - 1; i >= 0; i--) if (rot[i]) pick = i;
    grant_valid = |rot;
    grant_idx = SW'((pick + int'(ptr)) % WIDTH);
  end
endmodule

// File: rtl/channel_scanner.sv
// channel_scanner: round-robin readout of pending channels through the mux onto a valid/ready stream
module channel_scanner import channel_scanner_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DATA_LENGTH = DEF_DATA_LENGTH
) (
  input logic clk,
  input logic reset,
  channel_scanner_if.master bus
);
  localparam int SW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state, next_state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] grant_idx;
  logic grant_valid, load_sel, capture, accept;
  rr_arbiter #(.WIDTH(WIDTH)) u_arb (
    .req(bus.i_pending),
    .ptr(ptr),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  always_comb
    next_state = state == IDLE ? (grant_valid ? SELECT : IDLE) :
                 state == SELECT ? (bus.i_pending[bus.o_sel] ? OUTPUT : IDLE) :
                 bus.i_ready ? IDLE : OUTPUT;
  // a pending bit that dropped during SELECT is skipped without touching ptr
  always_comb begin
    load_sel = state == IDLE && grant_valid;
    capture = state == SELECT && bus.i_pending[bus.o_sel];
    accept = state == OUTPUT && bus.i_ready;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr <= '0;
      bus.o_sel <= '0;
      bus.o_ack <= '0;
      bus.o_data <= '0;
      bus.o_channel <= '0;
      bus.o_valid <= 1'b0;
    end else begin
      if (load_sel) bus.o_sel <= grant_idx;
      if (capture) begin
        bus.o_data <= bus.i_data;
        bus.o_channel <= bus.o_sel;
      end
      bus.o_ack <= capture ? WIDTH'(1) << bus.o_sel : '0;
      bus.o_valid <= capture | (bus.o_valid & ~accept);
      if (accept) ptr <= bus.o_channel == SW'(WIDTH - 1) ? '0 : bus.o_channel + 1'b1;
    end
endmodule

// File: tb/tb_channel_scanner.sv
// tb_channel_scanner: directed scenarios for the round-robin channel scanner
module tb_channel_scanner;
  import channel_scanner_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic [67:0] words [16];
  int compared = 0;
  int mismatched = 0;
  channel_scanner_if bus ();
  channel_scanner dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.i_data = words[bus.o_sel];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (bus.o_sel !== 4'd0) begin mismatched++; $display("FAIL reset_sel got %0d want 0", bus.o_sel); end
    compared++; if (bus.o_ack !== 16'h0) begin mismatched++; $display("FAIL reset_ack got %h want 0000", bus.o_ack); end
    compared++; if (bus.o_data !== 68'h0) begin mismatched++; $display("FAIL reset_data got %h want 0", bus.o_data); end
    compared++; if (bus.o_channel !== 4'd0) begin mismatched++; $display("FAIL reset_channel got %0d want 0", bus.o_channel); end
    compared++; if (bus.o_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    reset = 1'b0;
  endtask

  task automatic test_single;
    bus.i_pending = 16'h0020;
    tick;
    compared++; if (bus.o_sel !== 4'd5) begin mismatched++; $display("FAIL single_sel got %0d want 5", bus.o_sel); end
    compared++; if (bus.o_valid !== 1'b0) begin mismatched++; $display("FAIL single_early_valid got %b want 0", bus.o_valid); end
    tick;
    compared++; if (bus.o_ack !== 16'h0020) begin mismatched++; $display("FAIL single_ack got %h want 0020", bus.o_ack); end
    compared++; if (bus.o_valid !== 1'b1) begin mismatched++; $display("FAIL single_valid got %b want 1", bus.o_valid); end
    compared++; if (bus.o_data !== 68'hA5) begin mismatched++; $display("FAIL single_data got %h want a5", bus.o_data); end
    compared++; if (bus.o_channel !== 4'd5) begin mismatched++; $display("FAIL single_channel got %0d want 5", bus.o_channel); end
    bus.i_pending = 16'h0;
    bus.i_ready = 1'b1;
    tick;
    compared++; if (bus.o_ack !== 16'h0) begin mismatched++; $display("FAIL single_ack_len got %h want 0000", bus.o_ack); end
    compared++; if (bus.o_valid !== 1'b0) begin mismatched++; $display("FAIL single_accept got %b want 0", bus.o_valid); end
    bus.i_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    int n = 0;
    int last = 0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    bus.i_pending = 16'hFFFF;
    bus.i_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && n < 18; cyc++) begin
      tick;
      if (bus.o_valid) begin
        compared++; if (bus.o_channel !== 4'(n % 16)) begin mismatched++; $display("FAIL rr_channel word %0d got %0d want %0d", n, bus.o_channel, n % 16); end
        compared++; if (bus.o_data !== words[n % 16]) begin mismatched++; $display("FAIL rr_data word %0d got %h want %h", n, bus.o_data, words[n % 16]); end
        if (n > 0) begin
          compared++; if (cyc - last != 3) begin mismatched++; $display("FAIL rr_spacing word %0d got %0d want 3", n, cyc - last); end
        end
        last = cyc;
        n++;
      end
    end
    compared++; if (n != 18) begin mismatched++; $display("FAIL rr_timeout got %0d words want 18", n); end
    bus.i_pending = 16'h0;
    tick;
    bus.i_ready = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    bus.i_pending = 16'h0008;
    tick;
    compared++; if (bus.o_sel !== 4'd3) begin mismatched++; $display("FAIL bp_sel got %0d want 3", bus.o_sel); end
    tick;
    compared++; if (bus.o_ack !== 16'h0008) begin mismatched++; $display("FAIL bp_ack got %h want 0008", bus.o_ack); end
    bus.i_pending = 16'h0;
    for (int i = 0; i < 10; i++) begin
      compared++; if (bus.o_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid cycle %0d got %b want 1", i, bus.o_valid); end
      compared++; if (bus.o_data !== words[3]) begin mismatched++; $display("FAIL bp_data cycle %0d got %h want %h", i, bus.o_data, words[3]); end
      compared++; if (bus.o_channel !== 4'd3) begin mismatched++; $display("FAIL bp_channel cycle %0d got %0d want 3", i, bus.o_channel); end
      tick;
      compared++; if (bus.o_ack !== 16'h0) begin mismatched++; $display("FAIL bp_second_ack cycle %0d got %h want 0000", i, bus.o_ack); end
    end
    compared++; if (bus.o_valid !== 1'b1) begin mismatched++; $display("FAIL bp_hold got %b want 1", bus.o_valid); end
    bus.i_ready = 1'b1;
    tick;
    compared++; if (bus.o_valid !== 1'b0) begin mismatched++; $display("FAIL bp_accept got %b want 0", bus.o_valid); end
    bus.i_ready = 1'b0;
    tick;
    compared++; if (bus.o_valid !== 1'b0) begin mismatched++; $display("FAIL bp_idle_valid got %b want 0", bus.o_valid); end
    compared++; if (bus.o_sel !== 4'd3) begin mismatched++; $display("FAIL bp_idle_sel got %0d want 3", bus.o_sel); end
  endtask

  task automatic test_fairness;
    bus.i_pending = 16'h4000;
    tick;
    tick;
    compared++; if (bus.o_channel !== 4'd14 || bus.o_valid !== 1'b1) begin mismatched++; $display("FAIL fair_first got ch %0d v %b want ch 14 v 1", bus.o_channel, bus.o_valid); end
    bus.i_pending = 16'h0;
    bus.i_ready = 1'b1;
    tick;
    bus.i_pending = 16'h8004;
    tick;
    compared++; if (bus.o_sel !== 4'd15) begin mismatched++; $display("FAIL fair_sel15 got %0d want 15", bus.o_sel); end
    tick;
    compared++; if (bus.o_channel !== 4'd15 || bus.o_valid !== 1'b1) begin mismatched++; $display("FAIL fair_ch15 got ch %0d v %b want ch 15 v 1", bus.o_channel, bus.o_valid); end
    bus.i_pending = 16'h0004;
    tick;
    tick;
    compared++; if (bus.o_sel !== 4'd2) begin mismatched++; $display("FAIL fair_sel2 got %0d want 2", bus.o_sel); end
    tick;
    compared++; if (bus.o_channel !== 4'd2 || bus.o_valid !== 1'b1) begin mismatched++; $display("FAIL fair_ch2 got ch %0d v %b want ch 2 v 1", bus.o_channel, bus.o_valid); end
    bus.i_pending = 16'h0;
    tick;
    bus.i_ready = 1'b0;
    compared++; if (bus.o_valid !== 1'b0) begin mismatched++; $display("FAIL fair_done got %b want 0", bus.o_valid); end
  endtask

  task automatic test_dropped;
    bus.i_pending = 16'h0080;
    tick;
    compared++; if (bus.o_sel !== 4'd7) begin mismatched++; $display("FAIL drop_sel got %0d want 7", bus.o_sel); end
    bus.i_pending = 16'h0;
    tick;
    compared++; if (bus.o_ack !== 16'h0) begin mismatched++; $display("FAIL drop_ack got %h want 0000", bus.o_ack); end
    compared++; if (bus.o_valid !== 1'b0) begin mismatched++; $display("FAIL drop_valid got %b want 0", bus.o_valid); end
    bus.i_pending = 16'h0108;
    tick;
    compared++; if (bus.o_sel !== 4'd3) begin mismatched++; $display("FAIL drop_ptr got %0d want 3", bus.o_sel); end
    tick;
    compared++; if (bus.o_channel !== 4'd3 || bus.o_valid !== 1'b1) begin mismatched++; $display("FAIL drop_next got ch %0d v %b want ch 3 v 1", bus.o_channel, bus.o_valid); end
    bus.i_pending = 16'h0;
    bus.i_ready = 1'b1;
    tick;
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bus.i_pending = 16'h0200;
    tick;
    tick;
    compared++; if (bus.o_valid !== 1'b1 || bus.o_channel !== 4'd9) begin mismatched++; $display("FAIL rmid_pre got ch %0d v %b want ch 9 v 1", bus.o_channel, bus.o_valid); end
    #1;
    reset = 1'b1;
    #1;
    compared++; if (bus.o_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_valid got %b want 0", bus.o_valid); end
    compared++; if (bus.o_ack !== 16'h0) begin mismatched++; $display("FAIL rmid_ack got %h want 0000", bus.o_ack); end
    compared++; if (bus.o_data !== 68'h0) begin mismatched++; $display("FAIL rmid_data got %h want 0", bus.o_data); end
    compared++; if (bus.o_channel !== 4'd0) begin mismatched++; $display("FAIL rmid_channel got %0d want 0", bus.o_channel); end
    compared++; if (bus.o_sel !== 4'd0) begin mismatched++; $display("FAIL rmid_sel got %0d want 0", bus.o_sel); end
    bus.i_pending = 16'h0201;
    reset = 1'b0;
    tick;
    compared++; if (bus.o_sel !== 4'd0) begin mismatched++; $display("FAIL rmid_restart_sel got %0d want 0", bus.o_sel); end
    tick;
    compared++; if (bus.o_channel !== 4'd0 || bus.o_valid !== 1'b1) begin mismatched++; $display("FAIL rmid_restart got ch %0d v %b want ch 0 v 1", bus.o_channel, bus.o_valid); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) words[i] = {4'(i), 64'hC0DE_0000_0000_0000 | 64'(i)};
    words[5] = 68'hA5;
    reset = 1'b1;
    bus.i_pending = 16'h0;
    bus.i_ready = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_fairness;
    test_dropped;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
